// File: rtl/bank_xbar_rsp_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : bank_xbar_rsp_tx_if
//  Brief    : Request, response, return-beat and credit signals of the
//             bank-side read-return transmitter.
//  Revision : 1.0  initial release
// ============================================================================
interface bank_xbar_rsp_tx_if #(
    parameter int ROB_AW = 3,
    parameter int DW     = 128
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [1:0]        req_ch_id_i;
    logic              bank_req_valid_o;
    logic              bank_req_ready_i;
    logic [1:0]        bank_req_ch_id_o;
    logic [ROB_AW-1:0] bank_req_rob_num_o;
    logic              bank_rsp_valid_i;
    logic [1:0]        bank_rsp_ch_id_i;
    logic [ROB_AW-1:0] bank_rsp_rob_num_i;
    logic [DW-1:0]     bank_rsp_data_i;
    logic              sc_xbar_valid_o;
    logic [1:0]        sc_xbar_ch_id_o;
    logic [ROB_AW-1:0] sc_xbar_rob_num_o;
    logic [DW-1:0]     sc_xbar_data_o;
    logic [3:0]        ch_spw_pop_i;
    logic [3:0]        credit_avail_o;
    logic              err_o;

    // The transmitter itself.
    modport slave (
        input  req_valid_i, req_ch_id_i, bank_req_ready_i,
               bank_rsp_valid_i, bank_rsp_ch_id_i, bank_rsp_rob_num_i,
               bank_rsp_data_i, ch_spw_pop_i,
        output req_ready_o, bank_req_valid_o, bank_req_ch_id_o,
               bank_req_rob_num_o, sc_xbar_valid_o, sc_xbar_ch_id_o,
               sc_xbar_rob_num_o, sc_xbar_data_o, credit_avail_o, err_o
    );

    // The surrounding arbiter / bank pipeline / cross-bar.
    modport master (
        output req_valid_i, req_ch_id_i, bank_req_ready_i,
               bank_rsp_valid_i, bank_rsp_ch_id_i, bank_rsp_rob_num_i,
               bank_rsp_data_i, ch_spw_pop_i,
        input  req_ready_o, bank_req_valid_o, bank_req_ch_id_o,
               bank_req_rob_num_o, sc_xbar_valid_o, sc_xbar_ch_id_o,
               sc_xbar_rob_num_o, sc_xbar_data_o, credit_avail_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/bank_xbar_rsp_tx.sv
`default_nettype none
// ============================================================================
//  Module   : bank_xbar_rsp_tx
//  Brief    : Tags bank read requests with channel/ROB slot, forwards read
//             data to the cross-bar and tracks per-channel ROB credits.
//             Optional outstanding-slot checker: BANK_XBAR_RSP_TX_CHK_EN.
//  Revision : 1.0  initial release
// ============================================================================
module bank_xbar_rsp_tx #(
    parameter int ROB_AW = 3,
    parameter int DW     = 128
) (
    input  logic                clk_i,
    input  logic                rst_i,
    bank_xbar_rsp_tx_if.slave   bus
);
    localparam int              c_NCH         = 4;
    localparam int              c_ROB_DEPTH   = 1 << ROB_AW;
    localparam logic [ROB_AW:0] c_CREDIT_FULL = (ROB_AW+1)'(c_ROB_DEPTH);

    logic [ROB_AW-1:0] r_rob_ptr [c_NCH];
    logic [ROB_AW:0]   r_credit  [c_NCH];

    logic              w_ok;
    logic              w_fire;
    logic [c_NCH-1:0]  w_fire_ch;
    logic [c_NCH-1:0]  w_full;
    logic [c_NCH-1:0]  w_avail;

    always_comb begin
        w_ok      = (r_credit[bus.req_ch_id_i] != '0);
        w_fire    = bus.req_valid_i & bus.bank_req_ready_i & w_ok;
        w_fire_ch = '0;
        w_fire_ch[bus.req_ch_id_i] = w_fire;
        for (int n = 0; n < c_NCH; n++) begin
            w_full[n]  = (r_credit[n] == c_CREDIT_FULL);
            w_avail[n] = (r_credit[n] != '0);
        end
    end

    assign bus.bank_req_valid_o   = bus.req_valid_i & w_ok;
    assign bus.req_ready_o        = bus.bank_req_ready_i & w_ok;
    assign bus.bank_req_ch_id_o   = bus.req_ch_id_i;
    assign bus.bank_req_rob_num_o = r_rob_ptr[bus.req_ch_id_i];
    assign bus.credit_avail_o     = w_avail;

    // A fire and a pop on the same channel cancel out; a pop at full credit
    // is a protocol violation and saturates rather than overflowing.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int n = 0; n < c_NCH; n++) begin
                r_rob_ptr[n] <= '0;
                r_credit[n]  <= c_CREDIT_FULL;
            end
        end else begin
            for (int n = 0; n < c_NCH; n++) begin
                if (w_fire_ch[n]) begin
                    r_rob_ptr[n] <= r_rob_ptr[n] + 1'b1;
                end
                if (w_fire_ch[n] && !bus.ch_spw_pop_i[n]) begin
                    r_credit[n] <= r_credit[n] - 1'b1;
                end else if (!w_fire_ch[n] && bus.ch_spw_pop_i[n] && !w_full[n]) begin
                    r_credit[n] <= r_credit[n] + 1'b1;
                end
            end
        end
    end

    logic              r_sc_valid;
    logic [1:0]        r_sc_ch_id;
    logic [ROB_AW-1:0] r_sc_rob_num;
    logic [DW-1:0]     r_sc_data;

    // No backpressure: a held credit guarantees the ROB slot is free.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sc_valid   <= 1'b0;
            r_sc_ch_id   <= '0;
            r_sc_rob_num <= '0;
            r_sc_data    <= '0;
        end else begin
            r_sc_valid <= bus.bank_rsp_valid_i;
            if (bus.bank_rsp_valid_i) begin
                r_sc_ch_id   <= bus.bank_rsp_ch_id_i;
                r_sc_rob_num <= bus.bank_rsp_rob_num_i;
                r_sc_data    <= bus.bank_rsp_data_i;
            end
        end
    end

    assign bus.sc_xbar_valid_o   = r_sc_valid;
    assign bus.sc_xbar_ch_id_o   = r_sc_ch_id;
    assign bus.sc_xbar_rob_num_o = r_sc_rob_num;
    assign bus.sc_xbar_data_o    = r_sc_data;

`ifdef BANK_XBAR_RSP_TX_CHK_EN
    logic [c_ROB_DEPTH-1:0] r_outst     [c_NCH];
    logic [c_ROB_DEPTH-1:0] w_outst_nxt [c_NCH];
    logic                   r_err;
    logic                   w_rsp_err;
    logic                   w_fire_err;
    logic                   w_pop_err;

    // Response clears before fire sets, so a same-slot response and refire
    // in one cycle leaves the slot outstanding for the new request.
    always_comb begin
        w_rsp_err  = bus.bank_rsp_valid_i &
                     !r_outst[bus.bank_rsp_ch_id_i][bus.bank_rsp_rob_num_i];
        w_fire_err = w_fire &
                     r_outst[bus.req_ch_id_i][r_rob_ptr[bus.req_ch_id_i]];
        w_pop_err  = |(bus.ch_spw_pop_i & w_full);
        for (int n = 0; n < c_NCH; n++) begin
            w_outst_nxt[n] = r_outst[n];
            if (bus.bank_rsp_valid_i && (bus.bank_rsp_ch_id_i == 2'(n))) begin
                w_outst_nxt[n][bus.bank_rsp_rob_num_i] = 1'b0;
            end
            if (w_fire_ch[n]) begin
                w_outst_nxt[n][r_rob_ptr[n]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int n = 0; n < c_NCH; n++) begin
                r_outst[n] <= '0;
            end
            r_err <= 1'b0;
        end else begin
            for (int n = 0; n < c_NCH; n++) begin
                r_outst[n] <= w_outst_nxt[n];
            end
            if (w_rsp_err || w_fire_err || w_pop_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.err_o = r_err;
`else
    assign bus.err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bank_xbar_rsp_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bank_xbar_rsp_tx
//  Brief    : Directed self-checking bench for bank_xbar_rsp_tx.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bank_xbar_rsp_tx;
    localparam int c_ROB_AW = 3;
    localparam int c_DW     = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    bank_xbar_rsp_tx_if #(.ROB_AW(c_ROB_AW), .DW(c_DW)) bus ();

    bank_xbar_rsp_tx #(.ROB_AW(c_ROB_AW), .DW(c_DW)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one response beat and check it appears on the cross-bar next cycle.
    task automatic send_rsp(input logic [1:0] ch, input logic [2:0] rob, input logic [127:0] data);
        bus.bank_rsp_valid_i   = 1'b1;
        bus.bank_rsp_ch_id_i   = ch;
        bus.bank_rsp_rob_num_i = rob;
        bus.bank_rsp_data_i    = data;
        tick();
        bus.bank_rsp_valid_i   = 1'b0;
        #1;
        check("rsp_valid", 128'(bus.sc_xbar_valid_o), 128'd1);
        check("rsp_ch",    128'(bus.sc_xbar_ch_id_o), 128'(ch));
        check("rsp_rob",   128'(bus.sc_xbar_rob_num_o), 128'(rob));
        check("rsp_data",  bus.sc_xbar_data_o, data);
    endtask

    logic exp_err;

    initial begin
`ifdef BANK_XBAR_RSP_TX_CHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        bus.req_valid_i        = 1'b0;
        bus.req_ch_id_i        = 2'd0;
        bus.bank_req_ready_i   = 1'b1;
        bus.bank_rsp_valid_i   = 1'b0;
        bus.bank_rsp_ch_id_i   = 2'd0;
        bus.bank_rsp_rob_num_i = 3'd0;
        bus.bank_rsp_data_i    = '0;
        bus.ch_spw_pop_i       = 4'h0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        // Idle after reset
        check("rst_valid", 128'(bus.sc_xbar_valid_o), 128'd0);
        check("rst_data",  bus.sc_xbar_data_o, 128'd0);
        check("rst_avail", 128'(bus.credit_avail_o), 128'hF);
        check("rst_err",   128'(bus.err_o), 128'd0);

        // Channel 1 drains all eight credits
        bus.req_ch_id_i = 2'd1;
        bus.req_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("ch1_rob",   128'(bus.bank_req_rob_num_o), 128'(i));
            check("ch1_ready", 128'(bus.req_ready_o), 128'd1);
            tick();
        end
        #1;
        check("ch1_stall_ready", 128'(bus.req_ready_o), 128'd0);
        check("ch1_stall_valid", 128'(bus.bank_req_valid_o), 128'd0);
        check("ch1_avail",       128'(bus.credit_avail_o), 128'hD);
        bus.req_ch_id_i = 2'd2;
        #1;
        check("ch2_ready", 128'(bus.req_ready_o), 128'd1);
        check("ch2_rob",   128'(bus.bank_req_rob_num_o), 128'd0);
        check("ch2_chid",  128'(bus.bank_req_ch_id_o), 128'd2);
        tick();
        bus.req_valid_i = 1'b0;

        for (int i = 0; i < 8; i++) begin
            send_rsp(2'd1, 3'(i), 128'h100 + 128'(i));
        end
        send_rsp(2'd2, 3'd0, 128'h200);

        // One credit back on ch1 lets slot 0 be reused
        bus.ch_spw_pop_i = 4'b0010;
        tick();
        bus.ch_spw_pop_i = 4'h0;
        #1;
        check("pop_avail", 128'(bus.credit_avail_o), 128'hF);
        bus.req_ch_id_i = 2'd1;
        bus.req_valid_i = 1'b1;
        #1;
        check("wrap_ready", 128'(bus.req_ready_o), 128'd1);
        check("wrap_rob",   128'(bus.bank_req_rob_num_o), 128'd0);
        tick();
        bus.req_valid_i = 1'b0;
        #1;
        check("wrap_avail", 128'(bus.credit_avail_o), 128'hD);

        // Channel 0: credit 8 -> 5, then simultaneous fire and pop
        bus.req_ch_id_i = 2'd0;
        bus.req_valid_i = 1'b1;
        repeat (3) tick();
        bus.req_valid_i = 1'b0;
        send_rsp(2'd0, 3'd0, 128'h300);
        send_rsp(2'd0, 3'd1, 128'h301);
        send_rsp(2'd0, 3'd2, 128'h302);
        bus.req_valid_i  = 1'b1;
        bus.ch_spw_pop_i = 4'b0001;
        #1;
        check("firepop_rob", 128'(bus.bank_req_rob_num_o), 128'd3);
        tick();
        bus.ch_spw_pop_i = 4'h0;
        // Credit still 5: exactly five more fires, slots 4..7 then 0
        for (int k = 0; k < 5; k++) begin
            #1;
            check("ch0_ready", 128'(bus.req_ready_o), 128'd1);
            check("ch0_rob",   128'(bus.bank_req_rob_num_o), 128'((4 + k) % 8));
            tick();
        end
        #1;
        check("ch0_empty", 128'(bus.req_ready_o), 128'd0);
        bus.req_valid_i = 1'b0;

        // Channel 3 slots 0..6, then response on slot 6
        bus.req_ch_id_i = 2'd3;
        bus.req_valid_i = 1'b1;
        repeat (7) tick();
        bus.req_valid_i = 1'b0;
        send_rsp(2'd3, 3'd6, 128'hA5);
        tick();
        check("rsp_oneshot", 128'(bus.sc_xbar_valid_o), 128'd0);
        check("rsp_hold",    bus.sc_xbar_data_o, 128'hA5);
        check("rsp_hold_rb", 128'(bus.sc_xbar_rob_num_o), 128'd6);

        // Spurious response on a slot with nothing outstanding
        check("err_before", 128'(bus.err_o), 128'd0);
        send_rsp(2'd0, 3'd2, 128'h77);
        check("err_set",    128'(bus.err_o), 128'(exp_err));
        repeat (3) tick();
        check("err_sticky", 128'(bus.err_o), 128'(exp_err));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("err_clr",     128'(bus.err_o), 128'd0);
        check("reset_avail", 128'(bus.credit_avail_o), 128'hF);
        check("reset_valid", 128'(bus.sc_xbar_valid_o), 128'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
